// File: rtl/attitude_pd_ctrl_pkg.sv
// rtl/attitude_pd_ctrl_pkg.sv - shared constants, axis typedef and saturation helpers (package att_ctrl_pkg)
package att_ctrl_pkg;

    localparam int NUM_AXES = 3;

    // Widths along the datapath
    localparam int ERR_W   = 10;   // saturated error
    localparam int DDIFF_W = 7;    // saturated derivative difference
    localparam int D_W     = 12;   // derivative term
    localparam int SUM_W   = 13;   // speed mixing arithmetic
    localparam int SPD_W   = 11;   // motor speed

    // Saturation limits
    localparam int ERR_MAX   = 511;
    localparam int ERR_MIN   = -512;
    localparam int DDIFF_MAX = 63;
    localparam int DDIFF_MIN = -64;
    localparam int SPD_MAX   = 2047;

    localparam logic [SPD_W-1:0] MIN_RUN_SPEED = 11'd704;
    localparam logic [SPD_W-1:0] CAL_SPEED     = 11'd656;

    typedef enum logic [1:0] {
        AX_PTCH = 2'd0,
        AX_ROLL = 2'd1,
        AX_YAW  = 2'd2
    } axis_e;

    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [16:0] x);
        if (x > 17'(ERR_MAX))
            return 10'(ERR_MAX);
        else if (x < 17'(ERR_MIN))
            return 10'(ERR_MIN);
        else
            return x[ERR_W-1:0];
    endfunction

    function automatic logic signed [DDIFF_W-1:0] sat_ddiff(input logic signed [10:0] x);
        if (x > 11'(DDIFF_MAX))
            return 7'(DDIFF_MAX);
        else if (x < 11'(DDIFF_MIN))
            return 7'(DDIFF_MIN);
        else
            return x[DDIFF_W-1:0];
    endfunction

    function automatic logic [SPD_W-1:0] sat_spd(input logic signed [SUM_W-1:0] x);
        if (x < 13'sd0)
            return '0;
        else if (x > 13'(SPD_MAX))
            return 11'(SPD_MAX);
        else
            return x[SPD_W-1:0];
    endfunction

endpackage

// File: rtl/attitude_pd_ctrl_if.sv
// rtl/attitude_pd_ctrl_if.sv - attitude sample in / motor speed out bundle
//   master: drives vld, measured/desired attitude, thrst, inertial_cal; receives speeds, out_vld
//   slave : the controller side of the same signals
interface attitude_pd_ctrl_if;
    logic               vld;
    logic signed [15:0] ptch;
    logic signed [15:0] roll;
    logic signed [15:0] yaw;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic        [8:0]  thrst;
    logic               inertial_cal;
    logic        [10:0] frnt_spd;
    logic        [10:0] bck_spd;
    logic        [10:0] lft_spd;
    logic        [10:0] rght_spd;
    logic               out_vld;

    modport master (
        output vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw, thrst, inertial_cal,
        input  frnt_spd, bck_spd, lft_spd, rght_spd, out_vld
    );

    modport slave (
        input  vld, ptch, roll, yaw, d_ptch, d_roll, d_yaw, thrst, inertial_cal,
        output frnt_spd, bck_spd, lft_spd, rght_spd, out_vld
    );
endinterface

// File: rtl/err_hist_queue.sv
// rtl/err_hist_queue.sv - per-axis error history; returns the sample pushed DEPTH pushes ago, 0 until filled
//   clk, rst_n : clock, async active-low reset (clears contents and fill count)
//   push       : store din this cycle
//   din        : saturated error sample
//   prev_err   : oldest retained sample once DEPTH pushes have occurred, else 0
module err_hist_queue
    import att_ctrl_pkg::*;
#(
    parameter int DEPTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic signed [ERR_W-1:0] din,
    output logic signed [ERR_W-1:0] prev_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic signed [ERR_W-1:0] mem [DEPTH];
    logic        [CNT_W-1:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
            if (fill != CNT_W'(DEPTH))
                fill <= fill + CNT_W'(1);
        end
    end

    // Read happens before this cycle's push lands, so mem[DEPTH-1] is
    // exactly the sample from DEPTH pushes earlier.
    assign prev_err = (fill == CNT_W'(DEPTH)) ? mem[DEPTH-1] : '0;

endmodule

// File: rtl/attitude_pd_ctrl.sv
// rtl/attitude_pd_ctrl.sv - 3-stage PD attitude controller mixing pitch/roll/yaw into four motor speeds
//   clk, rst_n : clock, async active-low reset
//   bus        : attitude_pd_ctrl_if.slave (vld, attitude, desired attitude, thrst, inertial_cal in;
//                frnt/bck/lft/rght_spd, out_vld out)
//   ATT_CTRL_DTERM_EN : when defined, builds the derivative path with one history queue per axis;
//                       otherwise the D terms are zero
module attitude_pd_ctrl
    import att_ctrl_pkg::*;
#(
    parameter int D_QUEUE_DEPTH = 12,
    parameter int DTERM         = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    attitude_pd_ctrl_if.slave bus
);

    if (DTERM < 0 || DTERM > 31) begin : g_bad_dterm
        $error("DTERM must fit in 5 unsigned bits");
    end
    if (D_QUEUE_DEPTH < 1) begin : g_bad_depth
        $error("D_QUEUE_DEPTH must be at least 1");
    end

    logic signed [15:0] meas [NUM_AXES];
    logic signed [15:0] des  [NUM_AXES];

    assign meas[AX_PTCH] = bus.ptch;
    assign meas[AX_ROLL] = bus.roll;
    assign meas[AX_YAW]  = bus.yaw;
    assign des[AX_PTCH]  = bus.d_ptch;
    assign des[AX_ROLL]  = bus.d_roll;
    assign des[AX_YAW]   = bus.d_yaw;

    // Stage 1: saturated error
    logic                    s1_vld;
    logic [8:0]              s1_thrst;
    logic signed [ERR_W-1:0] s1_err [NUM_AXES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_thrst <= '0;
            for (int a = 0; a < NUM_AXES; a++)
                s1_err[a] <= '0;
        end else begin
            s1_vld <= bus.vld;
            if (bus.vld) begin
                s1_thrst <= bus.thrst;
                for (int a = 0; a < NUM_AXES; a++)
                    s1_err[a] <= sat_err(17'(meas[a]) - 17'(des[a]));
            end
        end
    end

    // P term: 0.625 * err via two arithmetic shifts
    logic signed [ERR_W-1:0] p_term [NUM_AXES];
    logic signed [D_W-1:0]   d_term [NUM_AXES];

    always_comb begin
        for (int a = 0; a < NUM_AXES; a++)
            p_term[a] = (s1_err[a] >>> 1) + (s1_err[a] >>> 3);
    end

`ifdef ATT_CTRL_DTERM_EN
    localparam logic signed [D_W-1:0] D_GAIN = D_W'(DTERM);

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_dpath
        logic signed [ERR_W-1:0]   prev_err;
        logic signed [DDIFF_W-1:0] d_diff;

        err_hist_queue #(
            .DEPTH (D_QUEUE_DEPTH)
        ) u_hist (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (s1_vld),
            .din      (s1_err[a]),
            .prev_err (prev_err)
        );

        assign d_diff    = sat_ddiff(11'(s1_err[a]) - 11'(prev_err));
        assign d_term[a] = D_W'(d_diff) * D_GAIN;
    end
`else
    for (genvar a = 0; a < NUM_AXES; a++) begin : g_no_dpath
        assign d_term[a] = '0;
    end
`endif

    // Stage 2: P and D terms
    logic                    s2_vld;
    logic [8:0]              s2_thrst;
    logic signed [ERR_W-1:0] s2_p [NUM_AXES];
    logic signed [D_W-1:0]   s2_d [NUM_AXES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_thrst <= '0;
            for (int a = 0; a < NUM_AXES; a++) begin
                s2_p[a] <= '0;
                s2_d[a] <= '0;
            end
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_thrst <= s1_thrst;
                for (int a = 0; a < NUM_AXES; a++) begin
                    s2_p[a] <= p_term[a];
                    s2_d[a] <= d_term[a];
                end
            end
        end
    end

    // Stage 3: motor mixing
    logic signed [SUM_W-1:0] base;
    logic signed [SUM_W-1:0] pd [NUM_AXES];
    logic signed [SUM_W-1:0] frnt_sum, bck_sum, lft_sum, rght_sum;

    always_comb begin
        for (int a = 0; a < NUM_AXES; a++)
            pd[a] = SUM_W'(s2_p[a]) + SUM_W'(s2_d[a]);
        base     = SUM_W'(MIN_RUN_SPEED) + SUM_W'(s2_thrst);
        frnt_sum = base - pd[AX_PTCH] - pd[AX_YAW];
        bck_sum  = base + pd[AX_PTCH] - pd[AX_YAW];
        lft_sum  = base - pd[AX_ROLL] + pd[AX_YAW];
        rght_sum = base + pd[AX_ROLL] + pd[AX_YAW];
    end

    logic [SPD_W-1:0] frnt_q, bck_q, lft_q, rght_q;
    logic             out_vld_q;

    // Calibration overrides the outputs only; results still drain from stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frnt_q    <= '0;
            bck_q     <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else if (bus.inertial_cal) begin
            frnt_q    <= CAL_SPEED;
            bck_q     <= CAL_SPEED;
            lft_q     <= CAL_SPEED;
            rght_q    <= CAL_SPEED;
            out_vld_q <= 1'b0;
        end else if (s2_vld) begin
            frnt_q    <= sat_spd(frnt_sum);
            bck_q     <= sat_spd(bck_sum);
            lft_q     <= sat_spd(lft_sum);
            rght_q    <= sat_spd(rght_sum);
            out_vld_q <= 1'b1;
        end else begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.frnt_spd = frnt_q;
    assign bus.bck_spd  = bck_q;
    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.out_vld  = out_vld_q;

endmodule

// File: tb/tb_attitude_pd_ctrl.sv
// tb/tb_attitude_pd_ctrl.sv - randomized self-checking bench for attitude_pd_ctrl
module tb_attitude_pd_ctrl;

    localparam int DEPTH = 12;
    localparam int DGAIN = 7;
`ifdef ATT_CTRL_DTERM_EN
    localparam bit D_ON = 1'b1;
`else
    localparam bit D_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    attitude_pd_ctrl_if bus();

    attitude_pd_ctrl #(
        .D_QUEUE_DEPTH (DEPTH),
        .DTERM         (DGAIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int sat(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Reference model: each accepted sample yields a result due two edges
    // after the edge that sampled it.
    typedef struct {
        int due;
        int f;
        int b;
        int l;
        int r;
    } exp_t;

    exp_t pend[$];
    exp_t x;
    int   hist [3][DEPTH];
    int   nvld = 0;
    int   cyc  = 0;
    int   ef = 0, eb = 0, el = 0, er = 0;
    bit   eov = 1'b0;
    int   ev [3];
    int   pdv [3];
    int   pv, dv, prevv, basev, slot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            nvld = 0;
            cyc  = 0;
            ef = 0; eb = 0; el = 0; er = 0;
            eov = 1'b0;
        end else begin
            cyc++;
            eov = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                x = pend.pop_front();
                if (!bus.inertial_cal) begin
                    ef = x.f; eb = x.b; el = x.l; er = x.r;
                    eov = 1'b1;
                end
            end
            if (bus.inertial_cal) begin
                ef = 656; eb = 656; el = 656; er = 656;
            end
            if (bus.vld) begin
                ev[0] = sat(int'(bus.ptch) - int'(bus.d_ptch), -512, 511);
                ev[1] = sat(int'(bus.roll) - int'(bus.d_roll), -512, 511);
                ev[2] = sat(int'(bus.yaw)  - int'(bus.d_yaw),  -512, 511);
                slot = nvld % DEPTH;
                for (int a = 0; a < 3; a++) begin
                    pv    = (ev[a] >>> 1) + (ev[a] >>> 3);
                    prevv = (nvld >= DEPTH) ? hist[a][slot] : 0;
                    dv    = D_ON ? sat(ev[a] - prevv, -64, 63) * DGAIN : 0;
                    hist[a][slot] = ev[a];
                    pdv[a] = pv + dv;
                end
                nvld++;
                basev = 704 + int'(bus.thrst);
                x.due = cyc + 2;
                x.f = sat(basev - pdv[0] - pdv[2], 0, 2047);
                x.b = sat(basev + pdv[0] - pdv[2], 0, 2047);
                x.l = sat(basev - pdv[1] + pdv[2], 0, 2047);
                x.r = sat(basev + pdv[1] + pdv[2], 0, 2047);
                pend.push_back(x);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_out_vld", int'(bus.out_vld), int'(eov));
            chk("cmp_frnt", int'(bus.frnt_spd), ef);
            chk("cmp_bck",  int'(bus.bck_spd),  eb);
            chk("cmp_lft",  int'(bus.lft_spd),  el);
            chk("cmp_rght", int'(bus.rght_spd), er);
        end
    end

    task automatic apply(input int pe, input int re, input int ye, input int th);
        int m;
        @(negedge clk);
        m = int'($urandom_range(40000)) - 20000;
        bus.ptch = 16'(m); bus.d_ptch = 16'(m - pe);
        m = int'($urandom_range(40000)) - 20000;
        bus.roll = 16'(m); bus.d_roll = 16'(m - re);
        m = int'($urandom_range(40000)) - 20000;
        bus.yaw = 16'(m);  bus.d_yaw = 16'(m - ye);
        bus.thrst = 9'(th);
        bus.vld = 1'b1;
    endtask

    task automatic run_lit(input string nm, input int pe, input int re, input int ye, input int th,
                           input int f, input int b, input int l, input int r);
        int k;
        bit seen;
        apply(pe, re, ye, th);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 6) begin
            @(negedge clk);
            bus.vld = 1'b0;
            k++;
            if (bus.out_vld) seen = 1'b1;
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_latency"}, k, 3);
            chk({nm, "_frnt"}, int'(bus.frnt_spd), f);
            chk({nm, "_bck"},  int'(bus.bck_spd),  b);
            chk({nm, "_lft"},  int'(bus.lft_spd),  l);
            chk({nm, "_rght"}, int'(bus.rght_spd), r);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    int seen_cnt;
    int e_p, e_r, e_y;

    initial begin
        bus.vld = 1'b0;
        bus.ptch = '0; bus.roll = '0; bus.yaw = '0;
        bus.d_ptch = '0; bus.d_roll = '0; bus.d_yaw = '0;
        bus.thrst = '0;
        bus.inertial_cal = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        chk("reset_out_vld", int'(bus.out_vld), 0);
        chk("reset_frnt", int'(bus.frnt_spd), 0);
        chk("reset_rght", int'(bus.rght_spd), 0);

        run_lit("level", 0, 0, 0, 0, 704, 704, 704, 704);

        do_reset();
        for (int i = 1; i <= 13; i++) begin
            if (i < 13)
                run_lit($sformatf("p100_vld%0d", i), 100, 0, 0, 0,
                        D_ON ? 201 : 642, D_ON ? 1207 : 766, 704, 704);
            else
                run_lit("p100_vld13", 100, 0, 0, 0, 642, 766, 704, 704);
        end

        do_reset();
        run_lit("clamp_lo", 600, 0, 0, 0, D_ON ? 0 : 386, D_ON ? 1463 : 1022, 704, 704);

        do_reset();
        run_lit("clamp_hi", 600, 0, -600, 511,
                D_ON ? 1224 : 1217, D_ON ? 2047 : 1853, D_ON ? 447 : 895, D_ON ? 447 : 895);

        // Calibration: outputs pinned to 656, no out_vld
        @(negedge clk);
        bus.inertial_cal = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 2) begin
                apply(40, -30, 20, 100);
            end else begin
                @(negedge clk);
                bus.vld = 1'b0;
            end
            if (bus.out_vld) seen_cnt++;
            if (i >= 1) begin
                chk("cal_frnt", int'(bus.frnt_spd), 656);
                chk("cal_lft",  int'(bus.lft_spd),  656);
            end
        end
        chk("cal_no_out_vld", seen_cnt, 0);
        @(negedge clk);
        bus.inertial_cal = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while a sample is in flight
        apply(100, 0, 0, 0);
        @(negedge clk);
        bus.vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_frnt", int'(bus.frnt_spd), 0);
        chk("midrst_bck",  int'(bus.bck_spd),  0);
        chk("midrst_out_vld", int'(bus.out_vld), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_vld) seen_cnt++;
        end
        chk("midrst_dropped", seen_cnt, 0);

        // Randomized traffic, including back-to-back vld, calibration windows and a reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            if ($urandom_range(1) == 1) begin
                if ($urandom_range(3) == 0) begin
                    e_p = int'($urandom_range(2000)) - 1000;
                    e_r = int'($urandom_range(2000)) - 1000;
                    e_y = int'($urandom_range(2000)) - 1000;
                end else begin
                    e_p = int'($urandom_range(300)) - 150;
                    e_r = int'($urandom_range(300)) - 150;
                    e_y = int'($urandom_range(300)) - 150;
                end
                apply(e_p, e_r, e_y, int'($urandom_range(511)));
            end else begin
                @(negedge clk);
                bus.vld = 1'b0;
            end
            bus.inertial_cal = ((i / 250) % 5 == 3);
        end
        @(negedge clk);
        bus.vld = 1'b0;
        bus.inertial_cal = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
